// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one RAM port between NREQ requesters
//
// Purpose:
//    Arbitrates NREQ requesters onto a single synchronous RAM port. Grants are
//    round-robin. The current owner can hold a lock that reserves the RAM
//    across a multi-access transaction. Every access is a registered RAM
//    cycle. Read data returns to the owner RD_LAT+1 cycles after its grant.
//
// Ports:
//    clk, reset_n          clock (posedge) and asynchronous active-low reset
//    req[NREQ]             level request, held with stable operands until gnt
//    lock[NREQ]            owner keeps the RAM after its access completes
//    wr_en_n[NREQ]         per-requester op: 0=write, 1=read
//    addr[NREQ*AW]         packed addresses, requester i at [i*AW +: AW]
//    wdata[NREQ*DW]        packed write data, requester i at [i*DW +: DW]
//    gnt[NREQ]             one-hot pulse: access issued this cycle
//    rvalid[NREQ]          one-hot pulse: rdata valid for that requester
//    rdata[DW]             shared read data, holds between rvalid pulses
//    mem_address, mem_data_write, mem_wr_en (0=write)   RAM command outputs
//    mem_data_in           RAM read data, valid RD_LAT cycles after address
module ram_port_arbiter #(
   parameter int NREQ   = 2,
   parameter int AW     = 7,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ-1:0]    wr_en_n,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      mem_address,
   output logic [DW-1:0]      mem_data_write,
   output logic               mem_wr_en,
   input  logic [DW-1:0]      mem_data_in
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RD_WAIT} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic             owner_vld_q, owner_vld_d;
   logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  rvalid_q, rvalid_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic [AW-1:0]    mem_address_q, mem_address_d;
   logic [DW-1:0]    mem_data_write_q, mem_data_write_d;
   logic             mem_wr_en_q, mem_wr_en_d;

   logic [AW-1:0]    addr_a  [NREQ];
   logic [DW-1:0]    wdata_a [NREQ];
   logic [NREQ-1:0]  eligible;
   logic [PW-1:0]    cand;
   logic [PW-1:0]    win_idx;
   logic             win_found;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign addr_a[i]  = addr[i*AW +: AW];
      assign wdata_a[i] = wdata[i*DW +: DW];
   end

   // A locked owner masks everyone else, even while it is not requesting.
   // owner_vld_q keeps the reset-time owner index from acting as a lock holder.
   always_comb begin
      eligible  = req;
      cand      = '0;
      win_idx   = '0;
      win_found = 1'b0;
      if (owner_vld_q && lock[owner_q]) begin
         eligible          = '0;
         eligible[owner_q] = req[owner_q];
      end
      // Search starts just after the last winner so it has lowest priority.
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NREQ);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      owner_d          = owner_q;
      owner_vld_d      = owner_vld_q;
      rd_cnt_d         = rd_cnt_q;
      gnt_d            = '0;
      rvalid_d         = '0;
      rdata_d          = rdata_q;
      mem_address_d    = mem_address_q;
      mem_data_write_d = mem_data_write_q;
      mem_wr_en_d      = mem_wr_en_q;

      case (state_q)
         S_IDLE: begin
            mem_wr_en_d = 1'b1;
            if (win_found) begin
               state_d          = S_ACCESS;
               ptr_d            = win_idx;
               owner_d          = win_idx;
               owner_vld_d      = 1'b1;
               mem_address_d    = addr_a[win_idx];
               mem_data_write_d = wdata_a[win_idx];
               mem_wr_en_d      = wr_en_n[win_idx];
               gnt_d[win_idx]   = 1'b1;
            end
         end
         S_ACCESS: begin
            if (!mem_wr_en_q) begin
               state_d     = S_IDLE;
               mem_wr_en_d = 1'b1;
            end else begin
               state_d  = S_RD_WAIT;
               rd_cnt_d = CW'(RD_LAT - 1);
            end
         end
         S_RD_WAIT: begin
            mem_wr_en_d = 1'b1;
            if (rd_cnt_q == '0) begin
               rdata_d           = mem_data_in;
               rvalid_d[owner_q] = 1'b1;
               state_d           = S_IDLE;
            end else begin
               rd_cnt_d = rd_cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= S_IDLE;
         ptr_q            <= PW'(NREQ - 1);
         owner_q          <= '0;
         owner_vld_q      <= 1'b0;
         rd_cnt_q         <= '0;
         gnt_q            <= '0;
         rvalid_q         <= '0;
         rdata_q          <= '0;
         mem_address_q    <= '0;
         mem_data_write_q <= '0;
         mem_wr_en_q      <= 1'b1;
      end else begin
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         owner_q          <= owner_d;
         owner_vld_q      <= owner_vld_d;
         rd_cnt_q         <= rd_cnt_d;
         gnt_q            <= gnt_d;
         rvalid_q         <= rvalid_d;
         rdata_q          <= rdata_d;
         mem_address_q    <= mem_address_d;
         mem_data_write_q <= mem_data_write_d;
         mem_wr_en_q      <= mem_wr_en_d;
      end
   end

   assign gnt            = gnt_q;
   assign rvalid         = rvalid_q;
   assign rdata          = rdata_q;
   assign mem_address    = mem_address_q;
   assign mem_data_write = mem_data_write_q;
   assign mem_wr_en      = mem_wr_en_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed bench for ram_port_arbiter with grant/read scoreboards
module tb_ram_port_arbiter;

   logic clk;
   logic reset_n;

   // instance a: RD_LAT=1
   logic [1:0]  a_req, a_lock, a_wr_en_n, a_gnt, a_rvalid;
   logic [13:0] a_addr;
   logic [15:0] a_wdata;
   logic [7:0]  a_rdata, a_mem_data_write, a_mem_data_in;
   logic [6:0]  a_mem_address;
   logic        a_mem_wr_en;

   // instance b: RD_LAT=3
   logic [1:0]  b_req, b_lock, b_wr_en_n, b_gnt, b_rvalid;
   logic [13:0] b_addr;
   logic [15:0] b_wdata;
   logic [7:0]  b_rdata, b_mem_data_write, b_mem_data_in;
   logic [6:0]  b_mem_address;
   logic        b_mem_wr_en;

   int errors = 0;
   int checks = 0;
   int got;

   int       q_ga[$], q_gb[$], q_ra_idx[$], q_rb_idx[$];
   logic [7:0] q_ra_dat[$], q_rb_dat[$];
   int       ma_i, mb_i;
   logic [7:0] ma_d, mb_d;

   ram_port_arbiter #(.NREQ(2), .AW(7), .DW(8), .RD_LAT(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .req(a_req), .lock(a_lock), .wr_en_n(a_wr_en_n),
      .addr(a_addr), .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata),
      .mem_address(a_mem_address), .mem_data_write(a_mem_data_write),
      .mem_wr_en(a_mem_wr_en), .mem_data_in(a_mem_data_in)
   );

   ram_port_arbiter #(.NREQ(2), .AW(7), .DW(8), .RD_LAT(3)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .req(b_req), .lock(b_lock), .wr_en_n(b_wr_en_n),
      .addr(b_addr), .wdata(b_wdata), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata),
      .mem_address(b_mem_address), .mem_data_write(b_mem_data_write),
      .mem_wr_en(b_mem_wr_en), .mem_data_in(b_mem_data_in)
   );

   // RAM models with 1- and 3-cycle read latency
   logic [7:0] a_mem [128];
   logic [7:0] b_mem [128];
   logic [7:0] a_pipe;
   logic [7:0] b_pipe [3];

   always @(posedge clk) begin
      if (!a_mem_wr_en) a_mem[a_mem_address] <= a_mem_data_write;
      a_pipe <= a_mem[a_mem_address];
      if (!b_mem_wr_en) b_mem[b_mem_address] <= b_mem_data_write;
      b_pipe[0] <= b_mem[b_mem_address];
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign a_mem_data_in = a_pipe;
   assign b_mem_data_in = b_pipe[2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // scoreboards: grants in order, read data per rvalid
   always @(negedge clk) begin
      if (a_gnt !== 2'b00) begin
         if (q_ga.size() == 0) chk("a_gnt_unexpected", a_gnt, 0);
         else begin
            ma_i = q_ga.pop_front();
            chk("a_gnt_order", a_gnt, 1 << ma_i);
         end
      end
      if (a_rvalid !== 2'b00) begin
         if (q_ra_idx.size() == 0) chk("a_rvalid_unexpected", a_rvalid, 0);
         else begin
            ma_i = q_ra_idx.pop_front();
            ma_d = q_ra_dat.pop_front();
            chk("a_rvalid_idx", a_rvalid, 1 << ma_i);
            chk("a_rdata_sb", a_rdata, ma_d);
         end
      end
      if (b_gnt !== 2'b00) begin
         if (q_gb.size() == 0) chk("b_gnt_unexpected", b_gnt, 0);
         else begin
            mb_i = q_gb.pop_front();
            chk("b_gnt_order", b_gnt, 1 << mb_i);
         end
      end
      if (b_rvalid !== 2'b00) begin
         if (q_rb_idx.size() == 0) chk("b_rvalid_unexpected", b_rvalid, 0);
         else begin
            mb_i = q_rb_idx.pop_front();
            mb_d = q_rb_dat.pop_front();
            chk("b_rvalid_idx", b_rvalid, 1 << mb_i);
            chk("b_rdata_sb", b_rdata, mb_d);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      a_req = '0; a_lock = '0; a_wr_en_n = '1; a_addr = '0; a_wdata = '0;
      b_req = '0; b_lock = '0; b_wr_en_n = '1; b_addr = '0; b_wdata = '0;
      repeat (3) tick();
      chk("rst_gnt", a_gnt, 0);
      chk("rst_rvalid", a_rvalid, 0);
      chk("rst_rdata", a_rdata, 0);
      chk("rst_addr", a_mem_address, 0);
      chk("rst_wdata", a_mem_data_write, 0);
      chk("rst_wr_en", a_mem_wr_en, 1);
      reset_n = 1'b1;

      // 1: simultaneous write(req0) / read(req1) to 0x10
      a_req = 2'b11; a_wr_en_n = 2'b10; a_addr = {7'h10, 7'h10}; a_wdata = {8'h00, 8'hA5};
      q_ga.push_back(0); q_ga.push_back(1);
      q_ra_idx.push_back(1); q_ra_dat.push_back(8'hA5);
      tick();
      chk("t1_gnt0", a_gnt, 2'b01);
      chk("t1_wr_en0", a_mem_wr_en, 0);
      chk("t1_addr", a_mem_address, 7'h10);
      chk("t1_wdata", a_mem_data_write, 8'hA5);
      a_req[0] = 1'b0;
      tick();
      chk("t1_idle_gnt", a_gnt, 0);
      chk("t1_wr_en1", a_mem_wr_en, 1);
      tick();
      chk("t1_gnt1", a_gnt, 2'b10);
      a_req[1] = 1'b0;
      tick();
      chk("t1_rv_early", a_rvalid, 0);
      tick();
      chk("t1_rvalid", a_rvalid, 2'b10);
      chk("t1_rdata", a_rdata, 8'hA5);

      // 2: both requesters writing continuously, six grants alternate
      a_req = 2'b11; a_wr_en_n = 2'b00; a_addr = {7'h21, 7'h20}; a_wdata = {8'h22, 8'h11};
      for (int i = 0; i < 6; i++) q_ga.push_back(i % 2);
      for (int c = 0; c < 12; c++) begin
         tick();
         chk($sformatf("t2_c%0d", c), a_gnt, (c % 2 == 0) ? (1 << ((c / 2) % 2)) : 0);
         if (c == 10) a_req = 2'b00;
      end

      // 3: locked req0 does three writes while req1 waits to read 0x20
      a_req = 2'b11; a_lock = 2'b01; a_wr_en_n = 2'b10; a_addr = {7'h20, 7'h30};
      a_wdata[7:0] = 8'h31;
      q_ga.push_back(0);
      for (int c = 0; c < 7; c++) begin
         tick();
         chk($sformatf("t3_c%0d", c), a_gnt, (c == 0 || c == 2 || c == 4) ? 1 : 0);
         if (c == 0 || c == 2 || c == 4) chk("t3_wdata", a_mem_data_write, 8'h31 + c / 2);
         if (c == 0 || c == 2) begin
            a_wdata[7:0] = a_wdata[7:0] + 8'h01;
            q_ga.push_back(0);
         end
         if (c == 4) a_req[0] = 1'b0;
      end
      q_ga.push_back(1);
      q_ra_idx.push_back(1); q_ra_dat.push_back(8'h11);
      a_lock = 2'b00;
      got = 0;
      for (int c = 0; c < 2 && got == 0; c++) begin
         tick();
         if (a_gnt === 2'b10) got = 1;
      end
      chk("t3_gnt1_after_unlock", got, 1);
      a_req[1] = 1'b0;
      got = 0;
      for (int c = 0; c < 4 && got == 0; c++) begin
         tick();
         if (a_rvalid !== 2'b00) got = 1;
      end
      chk("t3_rvalid_seen", got, 1);
      chk("t3_rdata", a_rdata, 8'h11);

      // 6: lock1 asserted while req0 owns the port is ignored
      a_req = 2'b01; a_wr_en_n = 2'b00; a_addr[6:0] = 7'h40; a_wdata[7:0] = 8'h44;
      q_ga.push_back(0);
      tick();
      chk("t6_gnt0", a_gnt, 2'b01);
      a_req = 2'b10; a_lock = 2'b10; a_addr[13:7] = 7'h41; a_wdata[15:8] = 8'h55;
      q_ga.push_back(1);
      tick();
      chk("t6_idle", a_gnt, 0);
      tick();
      chk("t6_gnt1", a_gnt, 2'b10);
      a_req = 2'b00; a_lock = 2'b00;
      tick();
      chk("t6_rdata_hold", a_rdata, 8'h11);

      // 4: RD_LAT=3 read of 0x7F, req0 contending during RD_WAIT
      b_req = 2'b01; b_wr_en_n = 2'b10; b_addr[6:0] = 7'h7F; b_wdata[7:0] = 8'h9C;
      q_gb.push_back(0);
      tick();
      chk("t4_wgnt", b_gnt, 2'b01);
      b_req = 2'b00;
      tick();
      b_req = 2'b10; b_addr[13:7] = 7'h7F;
      q_gb.push_back(1);
      q_rb_idx.push_back(1); q_rb_dat.push_back(8'h9C);
      tick();
      chk("t4_gnt1", b_gnt, 2'b10);
      chk("t4_addr0", b_mem_address, 7'h7F);
      b_req = 2'b01; b_addr[6:0] = 7'h00; b_wdata[7:0] = 8'h01;
      q_gb.push_back(0);
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk($sformatf("t4_addr%0d", c), b_mem_address, 7'h7F);
         chk($sformatf("t4_nognt%0d", c), b_gnt, 0);
         chk($sformatf("t4_norv%0d", c), b_rvalid, 0);
      end
      tick();
      chk("t4_rvalid", b_rvalid, 2'b10);
      chk("t4_rdata", b_rdata, 8'h9C);
      tick();
      chk("t4_gnt0_after", b_gnt, 2'b01);
      b_req = 2'b00;
      tick();

      // 5: reset during RD_WAIT drops the read
      b_req = 2'b10; b_wr_en_n = 2'b11; b_addr[13:7] = 7'h7F;
      q_gb.push_back(1);
      tick();
      chk("t5_gnt1", b_gnt, 2'b10);
      b_req = 2'b00;
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("t5_rst_gnt", b_gnt, 0);
      chk("t5_rst_rvalid", b_rvalid, 0);
      chk("t5_rst_rdata", b_rdata, 0);
      chk("t5_rst_addr", b_mem_address, 0);
      chk("t5_rst_wr_en", b_mem_wr_en, 1);
      tick();
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("t5_norv%0d", c), b_rvalid, 0);
      end
      b_req = 2'b10; b_wr_en_n = 2'b00; b_addr[13:7] = 7'h05; b_wdata[15:8] = 8'h66;
      q_gb.push_back(1);
      tick();
      chk("t5_gnt1_after_reset", b_gnt, 2'b10);
      b_req = 2'b00;
      tick();
      tick();

      chk("end_q_ga", q_ga.size(), 0);
      chk("end_q_gb", q_gb.size(), 0);
      chk("end_q_ra", q_ra_idx.size(), 0);
      chk("end_q_rb", q_rb_idx.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
